// File: rtl/serial_sub_pkg.sv
// Shared FSM encodings and width helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-counter width; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (diff = a - b), LSB first, one bit per clock.
// Define SERIAL_SUB_OVERFLOW_DETECT_EN to enable the signed-overflow flag.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;
  logic   load_c, step_c, last_c;

  logic [WIDTH-1:0] a_sh, b_sh;
  // Upper WIDTH-1 result bits; the incoming bit completes the word.
  logic [WIDTH-2:0] res_sh;
  logic             bin;
  logic [CNT_W-1:0] cnt;
  logic             d_c, bout_c;
  logic [WIDTH-1:0] res_wide_c;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bin),
    .d    (d_c),
    .bout (bout_c)
  );

  assign res_wide_c = {d_c, res_sh};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    step_c    = 1'b0;
    last_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step_c = 1'b1;
        if (cnt == CNT_LAST) begin
          last_c    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_RUN);
      done <= last_c;
      if (load_c) begin
        a_sh   <= a;
        b_sh   <= b;
        res_sh <= '0;
        bin    <= 1'b0;
        cnt    <= '0;
      end else if (step_c) begin
        a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
        res_sh <= res_wide_c[WIDTH-1:1];
        bin    <= bout_c;
        cnt    <= cnt + CNT_W'(1);
      end
      if (last_c) begin
        diff   <= res_wide_c;
        borrow <= bout_c;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_DETECT_EN
  logic a_msb, b_msb;

  // Two's-complement overflow: operand signs differ and result sign flips from a.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (load_c) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (last_c) ovf <= (a_msb != b_msb) && (d_c != a_msb);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W    = 8;
  localparam int          MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow, ovf;
  logic [W-1:0] diff;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] last_diff;
  logic         last_borrow, last_ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = (int'(x) - int'(y)) & MASK;
    return W'(r);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_SUB_OVERFLOW_DETECT_EN
    int sx, sy, r;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    r  = sx - sy;
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
`else
    return (x != x);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one edge; returns just after that edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    checks++;
    if ({busy, done, diff, borrow, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b diff=%h borrow=%b ovf=%b expected all zero",
               busy, done, diff, borrow, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b done=%b expected 0 0", busy, done);
    end
    last_diff   = '0;
    last_borrow = 1'b0;
    last_ovf    = 1'b0;
  endtask

  // Directed corner vectors followed by random ones; full timing and result check per op.
  task automatic test_arith();
    logic [W-1:0] va[$];
    logic [W-1:0] vb[$];
    logic [W-1:0] x, y;
    int edges, bc;
    va = '{8'd10, 8'd3,  8'h80, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h7F};
    vb = '{8'd3,  8'd10, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h80};
    for (int i = 0; i < 20; i++) begin
      va.push_back(W'($urandom_range(0, MASK)));
      vb.push_back(W'($urandom_range(0, MASK)));
    end
    for (int i = 0; i < va.size(); i++) begin
      x = va[i];
      y = vb[i];
      launch(x, y);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL arith_start[%0d] busy=%b done=%b expected 1 0", i, busy, done);
      end
      edges = 0;
      bc    = 1;
      while (done !== 1'b1 && edges < int'(W) + 4) begin
        tick();
        edges++;
        if (done !== 1'b1) begin
          if (busy === 1'b1) bc++;
          checks++;
          if (diff !== last_diff) begin
            failures++;
            $display("FAIL arith_hold[%0d] diff=%h expected %h", i, diff, last_diff);
          end
        end
      end
      checks++;
      if (edges !== int'(W) || bc !== int'(W)) begin
        failures++;
        $display("FAIL arith_latency[%0d] edges=%0d busy_cycles=%0d expected %0d %0d",
                 i, edges, bc, W, W);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || diff !== ref_diff(x, y) ||
          borrow !== ref_borrow(x, y) || ovf !== ref_ovf(x, y)) begin
        failures++;
        $display("FAIL arith_result[%0d] a=%h b=%h done=%b busy=%b diff=%h borrow=%b ovf=%b expected 1 0 %h %b %b",
                 i, x, y, done, busy, diff, borrow, ovf, ref_diff(x, y), ref_borrow(x, y), ref_ovf(x, y));
      end
      last_diff   = ref_diff(x, y);
      last_borrow = ref_borrow(x, y);
      last_ovf    = ref_ovf(x, y);
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== last_diff || borrow !== last_borrow) begin
        failures++;
        $display("FAIL arith_after[%0d] done=%b busy=%b diff=%h borrow=%b expected 0 0 %h %b",
                 i, done, busy, diff, borrow, last_diff, last_borrow);
      end
    end
  endtask

  task automatic test_start_ignored();
    int edges;
    launch(8'h55, 8'h11);
    edges = 0;
    while (done !== 1'b1 && edges < int'(W) + 4) begin
      if (edges == 2) begin
        @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
      end
      tick();
      start = 1'b0;
      edges++;
    end
    checks++;
    if (edges !== int'(W) || diff !== 8'h44 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored edges=%0d diff=%h borrow=%b expected %0d 44 0", edges, diff, borrow, W);
    end
    last_diff   = 8'h44;
    last_borrow = 1'b0;
    last_ovf    = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h44) begin
      failures++;
      $display("FAIL start_ignored_idle busy=%b done=%b diff=%h expected 0 0 44", busy, done, diff);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    launch(8'h9C, 8'h21);
    tick();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    checks++;
    if ({busy, done, diff, borrow, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_mid_run busy=%b done=%b diff=%h borrow=%b ovf=%b expected all zero",
               busy, done, diff, borrow, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < int'(W) + 4; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_no_done active_cycles=%0d expected 0", seen);
    end
    last_diff   = '0;
    last_borrow = 1'b0;
    last_ovf    = 1'b0;
  endtask

  task automatic test_back_to_back();
    int edges;
    launch(8'd9, 8'd2);
    edges = 0;
    while (done !== 1'b1 && edges < int'(W) + 4) begin
      tick();
      edges++;
    end
    checks++;
    if (done !== 1'b1 || diff !== 8'd7) begin
      failures++;
      $display("FAIL b2b_first done=%b diff=%h expected 1 07", done, diff);
    end
    launch(8'd5, 8'd5);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || diff !== 8'd7) begin
      failures++;
      $display("FAIL b2b_restart done=%b busy=%b diff=%h expected 0 1 07", done, busy, diff);
    end
    edges = 0;
    while (done !== 1'b1 && edges < int'(W) + 4) begin
      tick();
      edges++;
      if (done !== 1'b1) begin
        checks++;
        if (diff !== 8'd7 || busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_hold diff=%h busy=%b expected 07 1", diff, busy);
        end
      end
    end
    checks++;
    if (edges !== int'(W) || diff !== 8'd0 || borrow !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second edges=%0d diff=%h borrow=%b ovf=%b expected %0d 00 0 0",
               edges, diff, borrow, ovf, W);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
